// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared opcode and state encodings for the HI/LO multiply/divide controller.
package hilo_muldiv_ctrl_pkg;

  localparam int OP_W   = 3;
  localparam int ITER_W = 5;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } md_state_e;

  // Opcodes that write HI/LO (1..6); 0 and 7 are no-ops.
  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

  // Multiply/divide opcodes (1..4) hold the pipeline while they run.
  function automatic logic op_is_long(input logic [OP_W-1:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, DATA_W steps.
module hilo_muldiv_ctrl_div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dsr;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;

  // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  assign w_ge    = ~w_diff[DATA_W];

  // Load on start, step while busy, pulse done after the last step; abort drops everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dsr  <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_quo  <= dividend;
        r_rem  <= '0;
        r_dsr  <= divisor;
      end else if (r_busy) begin
        r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], w_ge};
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage sequencer for all HI/LO writes: multiply, divide and the two moves.
// Issues exactly one write per completed operation; flush or reset discard it.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [DATA_W-1:0] hi_cur,
  input  logic [DATA_W-1:0] lo_cur,
  input  logic              flush,
  output logic              stall,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hilo_hi,
  output logic [DATA_W-1:0] hilo_lo
);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);

  md_state_e           r_state;
  logic [ITER_W-1:0]   r_iter;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_signed;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_accept;
  logic                w_div_signed;
  logic                w_div_start;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [2*DATA_W-1:0] w_ext_a;
  logic [2*DATA_W-1:0] w_ext_b;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_div_busy;
  logic                w_div_done;
  logic [DATA_W-1:0]   w_div_q;
  logic [DATA_W-1:0]   w_div_r;
  logic [DATA_W-1:0]   w_q_fix;
  logic [DATA_W-1:0]   w_r_fix;

  assign w_accept     = (r_state == S_IDLE) && start && !flush && op_is_valid(op);
  assign w_div_signed = (op == MD_DIV);
  assign w_div_start  = w_accept && ((op == MD_DIV) || (op == MD_DIVU)) && (operand_b != '0);

  // The core divides magnitudes; the signs are reapplied in FIX.
  // Negating 0x8000_0000 gives itself, which is the correct magnitude unsigned.
  assign w_abs_a = (w_div_signed && operand_a[DATA_W-1]) ? -operand_a : operand_a;
  assign w_abs_b = (w_div_signed && operand_b[DATA_W-1]) ? -operand_b : operand_b;

  // Sign-extend for MULT, zero-extend for MULTU; the low 2*DATA_W bits are the product.
  assign w_ext_a = {{DATA_W{r_signed & r_a[DATA_W-1]}}, r_a};
  assign w_ext_b = {{DATA_W{r_signed & r_b[DATA_W-1]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_q_fix = r_neg_q ? -w_div_q : w_div_q;
  assign w_r_fix = r_neg_r ? -w_div_r : w_div_r;

  hilo_muldiv_ctrl_div_core #(
    .DATA_W (DATA_W)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .abort     (flush),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_div_q),
    .remainder (w_div_r)
  );

  // Controller FSM: accept in IDLE, run MUL/DIV/FIX, hold the result through DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_iter   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_iter <= '0;
            case (op)
              MD_MULT, MD_MULTU: begin
                r_a      <= operand_a;
                r_b      <= operand_b;
                r_signed <= (op == MD_MULT);
                r_state  <= S_MUL;
              end
              MD_DIV, MD_DIVU: begin
                if (operand_b == '0) begin
                  r_hi    <= operand_a;
                  r_lo    <= '1;
                  r_state <= S_DONE;
                end else begin
                  r_neg_q <= w_div_signed && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
                  r_neg_r <= w_div_signed && operand_a[DATA_W-1];
                  r_state <= S_DIV;
                end
              end
              MD_MTHI: begin
                r_hi    <= operand_a;
                r_lo    <= lo_cur;
                r_state <= S_DONE;
              end
              MD_MTLO: begin
                r_hi    <= hi_cur;
                r_lo    <= operand_a;
                r_state <= S_DONE;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            {r_hi, r_lo} <= w_prod;
            r_state      <= S_DONE;
          end
        end
        S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_iter <= r_iter + ITER_W'(1);
            if (r_iter == ITER_LAST) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (w_div_done) begin
            r_hi    <= w_r_fix;
            r_lo    <= w_q_fix;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle of a long op and every busy cycle; DONE never stalls
  // so the issuing instruction retires in the same cycle HILO is written.
  always_comb begin
    stall = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX) || w_div_busy ||
            ((r_state == S_IDLE) && start && op_is_long(op) && !flush);
  end

  assign hilo_we = (r_state == S_DONE) && !flush;
  assign hilo_hi = r_hi;
  assign hilo_lo = r_lo;

endmodule
